stage_pipe: RTL and testbench
=============================

STAGE_PIPE -- requirements
Module: stage_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width of every stage register.
REQ-002 Parameter DEPTH, default 4: number of pipeline stages (legal range 2..8); stage 0 is youngest.
REQ-003 Parameter TAGW, default 4: destination-tag width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  stage-0 input carries an instruction.
REQ-007 in_wen  in  1  instruction writes its tag.
REQ-008 in_tag  in  TAGW  destination tag of incoming instruction.
REQ-009 in_data  in  WIDTH  result value entering stage 0.
REQ-010 stall  in  DEPTH  per-stage hold; bit i holds stage i.
REQ-011 flush  in  DEPTH  per-stage clear; bit i invalidates stage i.
REQ-012 lookup_tag  in  TAGW  tag to search for forwarding.
REQ-013 lookup_hit  out  1  a valid, writing stage holds lookup_tag.
REQ-014 lookup_idx  out  $clog2(DEPTH)  index of matching stage.
REQ-015 lookup_data  out  WIDTH  data of matching stage.
REQ-016 out_valid, out_wen  out  1 each  valid/wen of stage DEPTH-1.
REQ-017 out_tag  out  TAGW  tag of stage DEPTH-1.
REQ-018 out_data  out  WIDTH  data of stage DEPTH-1.
REQ-019 occupancy  out  $clog2(DEPTH+1)  registered count of valid stages.

Function
REQ-020 Each stage holds {valid, wen, tag, data}; stage 0 loads {in_valid, in_wen, in_tag, in_data}; stage i>0 loads stage i-1.
REQ-021 Stage i with stall[i]=1 holds all fields unchanged; flush[i] is ignored that cycle (hold dominates clear).
REQ-022 Stage i with stall[i]=0 and flush[i]=1 loads valid=0, wen=0, tag=0, data=0.
REQ-023 Auto-bubble: stage i>0 with stall[i]=0, flush[i]=0, stall[i-1]=1 loads valid=0, wen=0 (tag/data load stage i-1 value, don't-care).
REQ-024 Stage i>0 with stall[i]=0 and stall[i-1]=0 and flush[i]=0 loads stage i-1 fields exactly; transfer latency 1 cycle per stage, DEPTH cycles input-to-out.
REQ-025 Stall pattern with stall[i]=1 and stall[i-1]=0 is legal: stage i-1 contents are overwritten (lost); block does not protect it.
REQ-026 Lookup is combinational over current stage registers: hit when valid&wen&(tag==lookup_tag).
REQ-027 On multiple hits the lowest index (youngest) stage wins; lookup_idx/lookup_data reflect it.
REQ-028 On no hit lookup_hit=0, lookup_idx=0, lookup_data=0.
REQ-029 Lookup does not see in_* inputs of the current cycle (no same-cycle bypass).
REQ-030 occupancy next = popcount of next-state valid bits; equals popcount of stage valids every cycle after reset; never exceeds DEPTH.
REQ-031 out_* are direct stage DEPTH-1 register outputs, no extra latency.

Reset
REQ-032 reset=1 at clock edge clears all stage fields to 0 and occupancy to 0, overriding stall and flush.
REQ-033 After reset: out_valid=0, out_wen=0, out_tag=0, out_data=0, lookup_hit=0, lookup_idx=0, lookup_data=0, occupancy=0.
REQ-034 Reset asserted mid-stream discards all in-flight entries; first post-reset in_valid appears at out after DEPTH cycles.

Verification (WIDTH=32, DEPTH=4, TAGW=4)
REQ-035 Flow: no stall/flush, push tag 3 data 0x11111111 at cycle 0 -> out_valid=1, out_tag=3, out_data=0x11111111 at cycle 4; occupancy 1 during cycles 1-4.
REQ-036 Forward priority: tag 5 data 0xA then tag 5 data 0xB pushed back-to-back -> lookup_tag=5 gives idx 0, data 0xB; after 0xB flushed in stage 0, gives idx 1, data 0xA.
REQ-037 Stall+bubble: stall=4'b0011 for 2 cycles with entry in stage 1 -> stage 1 holds, stage 2 receives valid=0 both cycles, occupancy drops as older entries exit.
REQ-038 Flush vs stall: stall[2]=1 and flush[2]=1 together -> stage 2 unchanged; next cycle flush[2]=1 only -> stage 2 valid=0, occupancy decrements.
REQ-039 wen gate: entry with in_wen=0, tag 7 in flight -> lookup_tag=7 gives lookup_hit=0, lookup_data=0.
REQ-040 Reset mid-operation: 4 valid entries, reset=1 with stall=4'b1111 -> next cycle occupancy=0, out_valid=0, lookup_hit=0.

Source files
------------

// File: rtl/stage_pipe.sv
// stage_pipe
//   Parameterised in-order result pipeline with per-stage hold and clear
//   controls and a tag-matched forwarding lookup. Each stage carries
//   {valid, wen, tag, data}; stage 0 is the youngest and stage DEPTH-1 drives
//   the out_* ports directly.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset; beats stall and flush
//   in_valid     stage-0 input carries an instruction
//   in_wen       incoming instruction writes its destination tag
//   in_tag       destination tag of the incoming instruction
//   in_data      result value entering stage 0
//   stall        per-stage hold, bit i holds stage i (hold beats clear)
//   flush        per-stage clear, bit i invalidates what stage i loads
//   lookup_tag   tag searched for forwarding
//   lookup_hit   some valid, writing stage holds lookup_tag
//   lookup_idx   index of the youngest matching stage (0 on miss)
//   lookup_data  data of the youngest matching stage (0 on miss)
//   out_valid    valid of stage DEPTH-1
//   out_wen      wen of stage DEPTH-1
//   out_tag      tag of stage DEPTH-1
//   out_data     data of stage DEPTH-1
//   occupancy    registered count of valid stages

module stage_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_wen,
  input  logic [TAGW-1:0]            in_tag,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [DEPTH-1:0]           stall,
  input  logic [DEPTH-1:0]           flush,
  input  logic [TAGW-1:0]            lookup_tag,
  output logic                       lookup_hit,
  output logic [$clog2(DEPTH)-1:0]   lookup_idx,
  output logic [WIDTH-1:0]           lookup_data,
  output logic                       out_valid,
  output logic                       out_wen,
  output logic [TAGW-1:0]            out_tag,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int OCCW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] stg_wen;
  logic [TAGW-1:0]  stg_tag  [DEPTH];
  logic [WIDTH-1:0] stg_data [DEPTH];

  logic [DEPTH-1:0] nxt_valid;
  logic [DEPTH-1:0] nxt_wen;
  logic [TAGW-1:0]  nxt_tag  [DEPTH];
  logic [WIDTH-1:0] nxt_data [DEPTH];

  function automatic logic [OCCW-1:0] count_ones(input logic [DEPTH-1:0] v);
    logic [OCCW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + OCCW'(v[i]);
    end
    return cnt;
  endfunction

  // Next-state per stage. Stage 0 has no upstream stall bit, so it is
  // handled on its own and the loop covers stages 1..DEPTH-1.
  always_comb begin
    nxt_valid = stg_valid;
    nxt_wen   = stg_wen;
    for (int i = 0; i < DEPTH; i++) begin
      nxt_tag[i]  = stg_tag[i];
      nxt_data[i] = stg_data[i];
    end

    if (!stall[0]) begin
      if (flush[0]) begin
        nxt_valid[0] = 1'b0;
        nxt_wen[0]   = 1'b0;
        nxt_tag[0]   = '0;
        nxt_data[0]  = '0;
      end else begin
        nxt_valid[0] = in_valid;
        nxt_wen[0]   = in_wen;
        nxt_tag[0]   = in_tag;
        nxt_data[0]  = in_data;
      end
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (!stall[i]) begin
        if (flush[i]) begin
          nxt_valid[i] = 1'b0;
          nxt_wen[i]   = 1'b0;
          nxt_tag[i]   = '0;
          nxt_data[i]  = '0;
        end else begin
          // A held upstream stage must not be duplicated downstream, so a
          // bubble is inserted; tag/data ride along but are meaningless.
          nxt_valid[i] = stall[i-1] ? 1'b0 : stg_valid[i-1];
          nxt_wen[i]   = stall[i-1] ? 1'b0 : stg_wen[i-1];
          nxt_tag[i]   = stg_tag[i-1];
          nxt_data[i]  = stg_data[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= '0;
      stg_wen   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stg_tag[i]  <= '0;
        stg_data[i] <= '0;
      end
      occupancy <= '0;
    end else begin
      stg_valid <= nxt_valid;
      stg_wen   <= nxt_wen;
      for (int i = 0; i < DEPTH; i++) begin
        stg_tag[i]  <= nxt_tag[i];
        stg_data[i] <= nxt_data[i];
      end
      occupancy <= count_ones(nxt_valid);
    end
  end

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_idx  = '0;
    lookup_data = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (stg_valid[i] && stg_wen[i] && (stg_tag[i] == lookup_tag)) begin
        lookup_hit  = 1'b1;
        lookup_idx  = IDXW'(i);
        lookup_data = stg_data[i];
      end
    end
  end

  assign out_valid = stg_valid[DEPTH-1];
  assign out_wen   = stg_wen[DEPTH-1];
  assign out_tag   = stg_tag[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];

endmodule

// File: tb/tb_stage_pipe.sv
module tb_stage_pipe;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_wen;
  logic [TAGW-1:0]  in_tag;
  logic [WIDTH-1:0] in_data;
  logic [DEPTH-1:0] stall;
  logic [DEPTH-1:0] flush;
  logic [TAGW-1:0]  lookup_tag;
  logic             lookup_hit;
  logic [1:0]       lookup_idx;
  logic [WIDTH-1:0] lookup_data;
  logic             out_valid;
  logic             out_wen;
  logic [TAGW-1:0]  out_tag;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       occupancy;

  int n_vec;
  int n_bad;

  stage_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_wen      (in_wen),
    .in_tag      (in_tag),
    .in_data     (in_data),
    .stall       (stall),
    .flush       (flush),
    .lookup_tag  (lookup_tag),
    .lookup_hit  (lookup_hit),
    .lookup_idx  (lookup_idx),
    .lookup_data (lookup_data),
    .out_valid   (out_valid),
    .out_wen     (out_wen),
    .out_tag     (out_tag),
    .out_data    (out_data),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_wen   = 1'b0;
    in_tag   = '0;
    in_data  = '0;
    stall    = '0;
    flush    = '0;
  endtask

  task automatic push(input logic [TAGW-1:0] t, input logic [WIDTH-1:0] d, input logic w);
    in_valid = 1'b1;
    in_wen   = w;
    in_tag   = t;
    in_data  = d;
    step();
    idle();
  endtask

  task automatic look(input logic [TAGW-1:0] t);
    lookup_tag = t;
    #1;
  endtask

  task automatic clear_all();
    flush = '1;
    step();
    idle();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    idle();
    lookup_tag = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_wen", out_wen, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_hit", lookup_hit, 0);
    chk("rst_idx", lookup_idx, 0);
    chk("rst_ldata", lookup_data, 0);
    chk("rst_occ", occupancy, 0);

    // straight flow, DEPTH cycles input to output
    push(4'd3, 32'h1111_1111, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      chk($sformatf("flow_occ_c%0d", c), occupancy, 1);
      chk($sformatf("flow_ov_c%0d", c), out_valid, (c == 4) ? 1 : 0);
    end
    chk("flow_out_tag", out_tag, 3);
    chk("flow_out_data", out_data, 32'h1111_1111);
    chk("flow_out_wen", out_wen, 1);
    step();
    chk("flow_drain_occ", occupancy, 0);
    chk("flow_drain_ov", out_valid, 0);

    // no same-cycle bypass from in_*
    in_valid = 1'b1; in_wen = 1'b1; in_tag = 4'd9; in_data = 32'h99;
    look(4'd9);
    chk("bypass_hit", lookup_hit, 0);
    chk("bypass_data", lookup_data, 0);
    idle();

    // forwarding priority: youngest wins, older visible after flush of stage 0
    push(4'd5, 32'hA, 1'b1);
    push(4'd5, 32'hB, 1'b1);
    look(4'd5);
    chk("fwd_hit", lookup_hit, 1);
    chk("fwd_idx", lookup_idx, 0);
    chk("fwd_data", lookup_data, 32'hB);
    stall = 4'b0010;
    flush = 4'b0001;
    step();
    idle();
    chk("fwd2_hit", lookup_hit, 1);
    chk("fwd2_idx", lookup_idx, 1);
    chk("fwd2_data", lookup_data, 32'hA);
    chk("fwd2_occ", occupancy, 1);
    clear_all();
    chk("clear_occ", occupancy, 0);

    // non-writing entry never forwards
    push(4'd7, 32'h77, 1'b0);
    look(4'd7);
    chk("wen_hit", lookup_hit, 0);
    chk("wen_data", lookup_data, 0);
    chk("wen_idx", lookup_idx, 0);
    chk("wen_occ", occupancy, 1);
    clear_all();

    // stall 0011 for two cycles: stage 1 holds, stage 2 gets bubbles
    push(4'd1, 32'h101, 1'b1);
    push(4'd2, 32'h202, 1'b1);
    push(4'd3, 32'h303, 1'b1);
    chk("sb_pre_occ", occupancy, 3);
    stall = 4'b0011;
    step();
    chk("sb1_occ", occupancy, 3);
    chk("sb1_ov", out_valid, 1);
    chk("sb1_otag", out_tag, 1);
    look(4'd2);
    chk("sb1_idx2", lookup_idx, 1);
    step();
    chk("sb2_occ", occupancy, 2);
    chk("sb2_ov", out_valid, 0);
    look(4'd2);
    chk("sb2_hit2", lookup_hit, 1);
    chk("sb2_idx2", lookup_idx, 1);
    look(4'd1);
    chk("sb2_hit1", lookup_hit, 0);
    idle();
    step();
    chk("sb3_occ", occupancy, 2);
    look(4'd3);
    chk("sb3_idx3", lookup_idx, 1);
    look(4'd2);
    chk("sb3_idx2", lookup_idx, 2);
    clear_all();

    // hold beats clear, then clear alone kills what stage 2 loads
    push(4'd6, 32'h66, 1'b1);
    push(4'd8, 32'h88, 1'b1);
    step();
    chk("fs_pre_occ", occupancy, 2);
    stall = 4'b0111;
    flush = 4'b0100;
    step();
    chk("fs1_occ", occupancy, 2);
    look(4'd6);
    chk("fs1_idx6", lookup_idx, 2);
    chk("fs1_data6", lookup_data, 32'h66);
    stall = 4'b0000;
    flush = 4'b0100;
    step();
    idle();
    chk("fs2_occ", occupancy, 1);
    look(4'd8);
    chk("fs2_hit8", lookup_hit, 0);
    look(4'd6);
    chk("fs2_idx6", lookup_idx, 3);
    chk("fs2_ov", out_valid, 1);
    chk("fs2_otag", out_tag, 6);
    clear_all();

    // reset mid-stream overrides stall
    push(4'd1, 32'h1, 1'b1);
    push(4'd2, 32'h2, 1'b1);
    push(4'd3, 32'h3, 1'b1);
    push(4'd4, 32'h4, 1'b1);
    chk("rm_pre_occ", occupancy, 4);
    chk("rm_pre_ov", out_valid, 1);
    reset = 1'b1;
    stall = 4'b1111;
    step();
    reset = 1'b0;
    idle();
    look(4'd1);
    chk("rm_occ", occupancy, 0);
    chk("rm_ov", out_valid, 0);
    chk("rm_hit", lookup_hit, 0);
    chk("rm_odata", out_data, 0);

    // first post-reset entry reaches out after DEPTH cycles
    push(4'd12, 32'hC0FFEE, 1'b1);
    step();
    step();
    chk("pr_ov_c3", out_valid, 0);
    step();
    chk("pr_ov_c4", out_valid, 1);
    chk("pr_otag", out_tag, 12);
    chk("pr_odata", out_data, 32'hC0FFEE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
